alu_arb: RTL

- Shares the single ALU between two issuing requesters, requester 0 (program sequencer) and requester 1 (secondary issue / loop engine).
- Arbitrates round-robin with an optional lock for multi-op sequences.
- Drives the ALU control and operand buses, and pipelines the combinational ALU result and flags back to the owning requester.
- Keeps per-requester sticky overflow flags.

---
 rtl/alu_arb.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/alu_arb.sv
// alu_arb: shares one combinational ALU between two issuing requesters.
// Round-robin arbitration with an optional ownership lock, a one-cycle
// execute stage, registered result/flag return and per-requester sticky
// overflow. Carry-in ops keep ownership so a carry chain is never split.
module alu_arb #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            rq_req,
    input  logic [1:0]            rq_lock,
    input  logic                  rq_log0,
    input  logic                  rq_log1,
    input  logic [1:0]            rq_hc0,
    input  logic [1:0]            rq_hc1,
    input  logic [2:0]            rq_sc0,
    input  logic [2:0]            rq_sc1,
    input  logic                  rq_sat0,
    input  logic                  rq_sat1,
    input  logic [DATA_WIDTH-1:0] rq_dtx0,
    input  logic [DATA_WIDTH-1:0] rq_dtx1,
    input  logic [DATA_WIDTH-1:0] rq_dty0,
    input  logic [DATA_WIDTH-1:0] rq_dty1,
    output logic [1:0]            rq_gnt,
    output logic [1:0]            rsp_vld,
    output logic [DATA_WIDTH-1:0] rsp_dt,
    output logic                  rsp_az,
    output logic                  rsp_an,
    output logic                  rsp_ac,
    output logic                  rsp_av,
    output logic [1:0]            sticky_av,
    input  logic [1:0]            sticky_clr,
    output logic                  ps_alu_en,
    output logic                  ps_alu_log,
    output logic [1:0]            ps_alu_hc,
    output logic [2:0]            ps_alu_sc,
    output logic                  ps_alu_sat,
    output logic [DATA_WIDTH-1:0] xb_dtx,
    output logic [DATA_WIDTH-1:0] xb_dty,
    input  logic [DATA_WIDTH-1:0] alu_xb_dt,
    input  logic                  alu_ps_az,
    input  logic                  alu_ps_an,
    input  logic                  alu_ps_ac,
    input  logic                  alu_ps_av
);

    // Arbitration state
    logic rr_ptr;
    logic lock_own;
    logic lock_id;

    // Execute stage: op loaded into the ALU last edge, result valid this cycle
    logic e_vld;
    logic e_id;
    logic e_sat;

    // Last issued control/operands, held on the buses while idle
    logic                  hold_log;
    logic [1:0]            hold_hc;
    logic [2:0]            hold_sc;
    logic [DATA_WIDTH-1:0] hold_dtx;
    logic [DATA_WIDTH-1:0] hold_dty;

    // Winner view of the current cycle
    logic                  lock_hit;
    logic                  xfer;
    logic                  win_id;
    logic                  win_log;
    logic [1:0]            win_hc;
    logic [2:0]            win_sc;
    logic                  win_sat;
    logic                  win_lock;
    logic                  win_carry;
    logic [DATA_WIDTH-1:0] win_dtx;
    logic [DATA_WIDTH-1:0] win_dty;
    logic [1:0]            sticky_set;

    assign lock_hit = lock_own & rq_req[lock_id];

    // Grant: held lock owner first, else the single requester, else rr_ptr breaks the tie
    always_comb begin
        // NOTE: rq_gnt is given a default before any branch so no path leaves it unassigned (no latch).
        rq_gnt = 2'b00;
        if (reset) begin
            if (lock_hit) begin
                rq_gnt[lock_id] = 1'b1;
            end else begin
                case (rq_req)
                    2'b01:   rq_gnt = 2'b01;
                    2'b10:   rq_gnt = 2'b10;
                    2'b11:   rq_gnt = rr_ptr ? 2'b10 : 2'b01;
                    default: rq_gnt = 2'b00;
                endcase
            end
        end
    end

    assign xfer     = |(rq_req & rq_gnt);
    assign win_id   = rq_gnt[1];
    assign win_log  = win_id ? rq_log1 : rq_log0;
    assign win_hc   = win_id ? rq_hc1  : rq_hc0;
    assign win_sc   = win_id ? rq_sc1  : rq_sc0;
    assign win_sat  = win_id ? rq_sat1 : rq_sat0;
    assign win_dtx  = win_id ? rq_dtx1 : rq_dtx0;
    assign win_dty  = win_id ? rq_dty1 : rq_dty0;
    assign win_lock = rq_lock[win_id];

    // Add/sub with carry-in (sc 010/011) must not have the other requester slip in between
    assign win_carry = ~win_log & (win_hc == 2'b00) & (win_sc[2:1] == 2'b01);

    assign ps_alu_en  = xfer;
    assign ps_alu_log = xfer ? win_log : hold_log;
    assign ps_alu_hc  = xfer ? win_hc  : hold_hc;
    assign ps_alu_sc  = xfer ? win_sc  : hold_sc;
    assign xb_dtx     = xfer ? win_dtx : hold_dtx;
    assign xb_dty     = xfer ? win_dty : hold_dty;
    assign ps_alu_sat = e_vld & e_sat;

    // Round-robin pointer and lock ownership
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_ptr   <= 1'b0;
            lock_own <= 1'b0;
            lock_id  <= 1'b0;
        end else if (xfer) begin
            rr_ptr   <= ~win_id;
            lock_own <= win_lock | win_carry;
            lock_id  <= win_id;
        end else if (lock_own && !rq_req[lock_id]) begin
            lock_own <= 1'b0;
        end
    end

    // Keep the last issued control and operands on the ALU buses while idle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_log <= 1'b0;
            hold_hc  <= 2'b00;
            hold_sc  <= 3'b000;
            hold_dtx <= '0;
            hold_dty <= '0;
        end else if (xfer) begin
            hold_log <= win_log;
            hold_hc  <= win_hc;
            hold_sc  <= win_sc;
            hold_dtx <= win_dtx;
            hold_dty <= win_dty;
        end
    end

    // Execute stage tracks which requester owns the result computed this cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_vld <= 1'b0;
            e_id  <= 1'b0;
            e_sat <= 1'b0;
        end else begin
            e_vld <= xfer;
            if (xfer) begin
                e_id  <= win_id;
                e_sat <= win_sat;
            end
        end
    end

    // Capture ALU result and flags, strobe the owning requester for one cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_vld <= 2'b00;
            rsp_dt  <= '0;
            rsp_az  <= 1'b0;
            rsp_an  <= 1'b0;
            rsp_ac  <= 1'b0;
            rsp_av  <= 1'b0;
        end else begin
            rsp_vld <= e_vld ? (e_id ? 2'b10 : 2'b01) : 2'b00;
            if (e_vld) begin
                rsp_dt <= alu_xb_dt;
                rsp_az <= alu_ps_az;
                rsp_an <= alu_ps_an;
                rsp_ac <= alu_ps_ac;
                rsp_av <= alu_ps_av;
            end
        end
    end

    assign sticky_set = {e_vld & e_id & alu_ps_av, e_vld & ~e_id & alu_ps_av};

    // Sticky overflow per requester; a set on the same edge as a clear wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sticky_av <= 2'b00;
        end else begin
            sticky_av <= sticky_set | (sticky_av & ~sticky_clr);
        end
    end

endmodule
